stream_sel_rr: RTL and testbench
================================

# stream_sel_rr

Parametrised, registered N-to-1 channel selector with valid/ready handshakes on every input and on the output. It generalises the fixed 4-input combinational selectors used across the core. It adds a one-entry output register, backpressure, and a selectable arbitration mode: external select or round-robin. It sits between multiple producers (e.g. fetch/LSU request sources, writeback sources) and a single downstream consumer.

## Interface
- WIDTH, 32, data width per channel
- NUM_CH, 4, number of input channels (2..16, need not be a power of two)
- MODE, 0, 0 = fixed select via control_in; 1 = round-robin among valid channels
- SEL_W, derived, max(1, clog2(NUM_CH)); not overridden by the instantiator
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle
- control_in  input  SEL_W  channel select, used only when MODE=0
- out_data  output  WIDTH  registered data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts out_data this cycle
- out_sel  output  SEL_W  index of the channel that supplied out_data

## Operation
- Output stage is a single register (out_data, out_sel, out_valid).
- load_en = !out_valid || out_ready (register empty, or draining this cycle).
- Grant selection, combinational:
  - MODE=0: grant = control_in if control_in < NUM_CH and in_valid[control_in], else none. Out-of-range control_in grants nothing and raises no ready.
  - MODE=1: grant = first i with in_valid[i], searching from rr_ptr upward and wrapping NUM_CH-1 -> 0; none if no valid.
- in_ready[i] = load_en && (grant == i) && grant exists. Ready depends on in_valid of the granted channel only.
- Input transfer on channel g: in_valid[g] && in_ready[g]. Next cycle: out_data = in_data[g], out_sel = g, out_valid = 1.
- load_en with no transfer: out_valid <= 0; out_data and out_sel hold their last value.
- Stall (out_valid && !out_ready): out_data, out_sel, out_valid hold; all in_ready = 0.
- rr_ptr (MODE=1 only): on an input transfer from g, rr_ptr <= (g == NUM_CH-1) ? 0 : g+1. Otherwise it holds. In MODE=0, rr_ptr stays 0.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, rr_ptr = 0. in_ready is therefore combinationally 0 until a valid arrives.
- Latency: 1 cycle, from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous drain and refill in the same cycle is required; no bubble is allowed.
- Simultaneous valids (MODE=1): exactly one channel is granted per cycle. No channel waits more than NUM_CH-1 transfers once it is valid.
- control_in changes during a stall have no effect on the held word. The new select applies on the next load_en cycle.
- rst asserted mid-transfer: all state is forced to reset values at that edge. The in-flight word is dropped, in_ready is 0 in the reset cycle, and rr_ptr returns to 0.
- No combinational path from out_ready to out_valid or out_data. The path out_ready -> in_ready is permitted.

## Structure
- Shared package/header rv_sel_pkg: mode constants SEL_MODE_FIXED = 0, SEL_MODE_RR = 1, and a clog2 function for SEL_W.
- Sub-module rr_arbiter (parameters NUM_CH, SEL_W; inputs req, ptr; outputs grant_vld, grant_idx) holds the wrap-around priority search. It is instantiated only in MODE=1 via a generate block.
- Top level holds the grant mux, the output register and rr_ptr.

## Test plan
- Reset: rst = 1 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0 throughout. First word appears one cycle after rst falls.
- MODE=0, NUM_CH=4, WIDTH=32: control_in = 2, in_data[2] = 32'hDEAD_BEEF, out_ready = 1 -> in_ready = 4'b0100. Next cycle out_data = 32'hDEAD_BEEF, out_sel = 2.
- MODE=0, NUM_CH=3: control_in = 3 with all valid -> in_ready = 0 and out_valid stays 0.
- MODE=1, NUM_CH=4: all valid, out_ready = 1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with no bubbles.
- MODE=1, NUM_CH=5: only channels 1 and 4 valid -> out_sel sequence 1,4,1,4. rr_ptr wraps from 4 to 0 and grants 1.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data and out_sel hold and in_ready = 0. On out_ready = 1, drain and refill occur in the same cycle.

Source files
------------

// File: rtl/rv_sel_pkg.sv
// Shared definitions for the stream channel selectors: arbitration mode
// constants and the select-index width helper.
package rv_sel_pkg;

  localparam int SEL_MODE_FIXED = 0;
  localparam int SEL_MODE_RR    = 1;

  // Number of bits needed to index n items (ceil(log2(n))).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Select width is never zero, even for a degenerate single channel.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Wrap-around priority search: grants the first requester at or above ptr,
// wrapping from NUM_CH-1 back to 0.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              grant_vld,
  output logic [SEL_W-1:0]  grant_idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  // NOTE: every always_comb output gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int c;
      c = int'(ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (c < NUM_CH && req[c]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_sel_rr.sv
// Registered N-to-1 valid/ready channel selector with either an external
// select or round-robin arbitration, feeding a one-entry output register.
module stream_sel_rr
  import rv_sel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int MODE   = SEL_MODE_FIXED,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        control_in,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             transfer;
  logic [WIDTH-1:0] mux_data;

  // Register is free when empty or being drained this cycle, so a full
  // register refills in the same cycle it drains.
  assign load_en  = !out_valid || out_ready;
  assign transfer = !rst && load_en && grant_vld;

  generate
    if (MODE == SEL_MODE_RR) begin : g_rr
      logic [SEL_W-1:0] rr_ptr;

      rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
      ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
      );

      // Pointer moves just past the channel that was served.
      always_ff @(posedge clk) begin
        if (rst) begin
          rr_ptr <= '0;
        end else if (transfer) begin
          rr_ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
      end
    end else begin : g_fixed
      // Out-of-range selects match no channel and therefore grant nothing.
      always_comb begin
        grant_vld = 1'b0;
        grant_idx = control_in;
        for (int i = 0; i < NUM_CH; i++) begin
          if (control_in == SEL_W'(i)) grant_vld = in_valid[i];
        end
      end
    end
  endgenerate

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready is held low during reset so nothing is consumed and then dropped.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = transfer && (grant_idx == SEL_W'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        out_data <= mux_data;
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_sel_rr.sv
// Directed bench for stream_sel_rr: fixed-select (4 and 3 channels) and
// round-robin (4 and 5 channels) instances driven from vector tables.
module tb_stream_sel_rr;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed select, 4 channels
  logic [127:0] f4_data;
  logic [3:0]   f4_valid, f4_ready;
  logic [1:0]   f4_ctl, f4_sel;
  logic [31:0]  f4_odata;
  logic         f4_ovalid, f4_ordy;

  // Fixed select, 3 channels
  logic [95:0]  f3_data;
  logic [2:0]   f3_valid, f3_ready;
  logic [1:0]   f3_ctl, f3_sel;
  logic [31:0]  f3_odata;
  logic         f3_ovalid, f3_ordy;

  // Round-robin, 4 channels
  logic [127:0] r4_data;
  logic [3:0]   r4_valid, r4_ready;
  logic [1:0]   r4_ctl, r4_sel;
  logic [31:0]  r4_odata;
  logic         r4_ovalid, r4_ordy;

  // Round-robin, 5 channels
  logic [159:0] r5_data;
  logic [4:0]   r5_valid, r5_ready;
  logic [2:0]   r5_ctl, r5_sel;
  logic [31:0]  r5_odata;
  logic         r5_ovalid, r5_ordy;

  stream_sel_rr #(.WIDTH(32), .NUM_CH(4), .MODE(0)) dut_f4 (
    .clk(clk), .rst(rst), .in_data(f4_data), .in_valid(f4_valid), .in_ready(f4_ready),
    .control_in(f4_ctl), .out_data(f4_odata), .out_valid(f4_ovalid), .out_ready(f4_ordy),
    .out_sel(f4_sel));

  stream_sel_rr #(.WIDTH(32), .NUM_CH(3), .MODE(0)) dut_f3 (
    .clk(clk), .rst(rst), .in_data(f3_data), .in_valid(f3_valid), .in_ready(f3_ready),
    .control_in(f3_ctl), .out_data(f3_odata), .out_valid(f3_ovalid), .out_ready(f3_ordy),
    .out_sel(f3_sel));

  stream_sel_rr #(.WIDTH(32), .NUM_CH(4), .MODE(1)) dut_r4 (
    .clk(clk), .rst(rst), .in_data(r4_data), .in_valid(r4_valid), .in_ready(r4_ready),
    .control_in(r4_ctl), .out_data(r4_odata), .out_valid(r4_ovalid), .out_ready(r4_ordy),
    .out_sel(r4_sel));

  stream_sel_rr #(.WIDTH(32), .NUM_CH(5), .MODE(1)) dut_r5 (
    .clk(clk), .rst(rst), .in_data(r5_data), .in_valid(r5_valid), .in_ready(r5_ready),
    .control_in(r5_ctl), .out_data(r5_odata), .out_valid(r5_ovalid), .out_ready(r5_ordy),
    .out_sel(r5_sel));

  typedef struct {
    logic [1:0]  ctl;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    f4_data = {32'h4444_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
    f3_data = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    r4_data = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    r5_data = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    f4_ctl = 2'd0; f3_ctl = 2'd0; r4_ctl = 2'd0; r5_ctl = 3'd0;
    f4_valid = '1; f3_valid = '1; r4_valid = '1; r5_valid = '1;
    f4_ordy = 1'b1; f3_ordy = 1'b1; r4_ordy = 1'b1; r5_ordy = 1'b1;
    rst = 1'b1;

    // ctl, valid, out_ready | in_ready, out_valid, out_sel, out_data (registered, this cycle)
    vecs[0]  = '{2'd2, 4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0, 32'h0000_0000};
    vecs[1]  = '{2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd2, 32'hDEAD_BEEF};
    vecs[2]  = '{2'd3, 4'b0111, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h2222_0001};
    vecs[3]  = '{2'd0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd1, 32'h2222_0001};
    vecs[4]  = '{2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h1111_0000};
    vecs[5]  = '{2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h1111_0000};
    vecs[6]  = '{2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h1111_0000};
    vecs[7]  = '{2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0, 32'h1111_0000};
    vecs[8]  = '{2'd2, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h4444_0003};
    vecs[9]  = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd3, 32'h4444_0003};
    vecs[10] = '{2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hDEAD_BEEF};

    // Reset held two cycles with every channel valid.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_f4_ready",  32'(f4_ready),  32'h0);
      check("rst_f4_valid",  32'(f4_ovalid), 32'h0);
      check("rst_f4_data",   f4_odata,       32'h0);
      check("rst_f4_sel",    32'(f4_sel),    32'h0);
      check("rst_r4_ready",  32'(r4_ready),  32'h0);
      check("rst_r4_valid",  32'(r4_ovalid), 32'h0);
    end
    rst = 1'b0;
    f3_valid = '0; r4_valid = '0; r5_valid = '0;

    // Fixed select table on the 4-channel instance.
    for (int i = 0; i < 11; i++) begin
      f4_ctl   = vecs[i].ctl;
      f4_valid = vecs[i].valid;
      f4_ordy  = vecs[i].ordy;
      #1;
      check($sformatf("f4_ready[%0d]", i), 32'(f4_ready),  32'(vecs[i].exp_ready));
      check($sformatf("f4_valid[%0d]", i), 32'(f4_ovalid), 32'(vecs[i].exp_valid));
      check($sformatf("f4_sel[%0d]", i),   32'(f4_sel),    32'(vecs[i].exp_sel));
      check($sformatf("f4_data[%0d]", i),  f4_odata,       vecs[i].exp_data);
      tick();
    end
    f4_valid = '0;
    f4_ordy  = 1'b1;

    // Out-of-range select on a 3-channel instance grants nothing.
    do_reset();
    f3_valid = 3'b111;
    f3_ctl   = 2'd3;
    f3_ordy  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("f3_oor_ready", 32'(f3_ready),  32'h0);
      check("f3_oor_valid", 32'(f3_ovalid), 32'h0);
      tick();
    end
    f3_ctl = 2'd2;
    #1;
    check("f3_ch2_ready", 32'(f3_ready), 32'b100);
    tick();
    f3_valid = '0;
    #1;
    check("f3_ch2_valid", 32'(f3_ovalid), 32'h1);
    check("f3_ch2_sel",   32'(f3_sel),    32'h2);
    check("f3_ch2_data",  f3_odata,       32'h3333_0002);

    // Round-robin, all four valid: 0,1,2,3,0,1,2,3 with no bubbles.
    do_reset();
    r4_valid = 4'b1111;
    r4_ordy  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("r4_ready[%0d]", k), 32'(r4_ready), 32'(1) << (k % 4));
      if (k == 0) begin
        check("r4_first_valid", 32'(r4_ovalid), 32'h0);
      end else begin
        check($sformatf("r4_valid[%0d]", k), 32'(r4_ovalid), 32'h1);
        check($sformatf("r4_sel[%0d]", k),   32'(r4_sel),    32'((k - 1) % 4));
        check($sformatf("r4_data[%0d]", k),  r4_odata,       32'hC0DE_0000 + 32'((k - 1) % 4));
      end
      tick();
    end

    // Reset with a word in flight and the pointer at 1: word dropped, pointer back to 0.
    rst = 1'b1;
    #1;
    check("r4_midrst_ready", 32'(r4_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("r4_midrst_valid", 32'(r4_ovalid), 32'h0);
    check("r4_midrst_data",  r4_odata,       32'h0);
    check("r4_ptr_cleared",  32'(r4_ready),  32'b0001);
    tick();
    r4_valid = '0;
    #1;
    check("r4_after_rst_sel", 32'(r4_sel), 32'h0);

    // Round-robin, 5 channels, only 1 and 4 valid: 1,4,1,4 with pointer wrap.
    do_reset();
    r5_valid = 5'b10010;
    r5_ordy  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("r5_ready[%0d]", k), 32'(r5_ready), (k % 2 == 0) ? 32'b00010 : 32'b10000);
      if (k > 0) begin
        check($sformatf("r5_valid[%0d]", k), 32'(r5_ovalid), 32'h1);
        check($sformatf("r5_sel[%0d]", k),   32'(r5_sel),    (k % 2 == 1) ? 32'd1 : 32'd4);
        check($sformatf("r5_data[%0d]", k),  r5_odata,       (k % 2 == 1) ? 32'h5555_0001 : 32'h5555_0004);
      end
      tick();
    end
    r5_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
